// File: rtl/track_render_pipe_pkg.sv
// Shared types and constants for the lane/obstacle/player renderer.
// Obstacle lane field is 3 bits wide so any lane count up to 8 fits.
package track_render_pipe_pkg;
  localparam int LANE_W = 3;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic              active;
    logic [LANE_W-1:0] lane;
    logic [10:0]       position;
  } obstacle_t;

  localparam logic [11:0] OBSTACLE_PALETTE [8] = '{
    12'hF00, 12'h0F0, 12'hFF0, 12'hF0F, 12'h00F, 12'hF80, 12'h8F0, 12'hFFF
  };

  function automatic logic [11:0] lane_bg(input logic [LANE_W-1:0] lane);
    return {7'd0, lane, 2'd0};
  endfunction
endpackage

// File: rtl/track_render_pipe_hit.sv
// Half-open horizontal interval test of one sprite against the current pixel.
// Compared in 12 bits so position+WIDTH never wraps; the right edge clips at the screen.
module track_hit_unit
  import track_render_pipe_pkg::*;
#(
  parameter int WIDTH        = 224,
  parameter int SCREEN_WIDTH = 1024
) (
  input  obstacle_t         obs,
  input  logic [LANE_W-1:0] lane,
  input  logic [10:0]       hcount,
  input  logic              margin,
  output logic              hit
);
  logic [11:0] left, right, h;

  assign left  = {1'b0, obs.position};
  assign right = left + 12'(WIDTH);
  assign h     = {1'b0, hcount};
  assign hit   = obs.active && !margin && (obs.lane == lane) &&
                 (h >= left) && (h < right) && (h < 12'(SCREEN_WIDTH));
endmodule

// File: rtl/track_render_pipe.sv
// Three-stage lane/obstacle/player renderer with per-frame sprite snapshot,
// sync/blank delay matching and a once-per-frame collision pulse.
module track_render_pipe
  import track_render_pipe_pkg::*;
#(
  parameter int          SCREEN_WIDTH    = 1024,
  parameter int          SCREEN_HEIGHT   = 768,
  parameter int          NUM_LANES       = 3,
  parameter int          NUM_OBSTACLES   = 10,
  parameter int          OBSTACLE_MARGIN = 16,
  parameter int          PLAYER_WIDTH    = 64,
  parameter logic [11:0] PLAYER_COLOR    = 12'h0FF,
  localparam int         PL_W            = $clog2(NUM_LANES)
) (
  input  logic                                system_clock_in,
  input  logic                                system_reset_in,
  input  logic [10:0]                         hcount,
  input  logic [9:0]                          vcount,
  input  logic                                hsync,
  input  logic                                vsync,
  input  logic                                blank,
  input  obstacle_t [NUM_OBSTACLES-1:0]       obstacles,
  input  logic [PL_W-1:0]                     player_lane,
  input  logic [10:0]                         player_x,
  output logic [11:0]                         rgb,
  output logic                                hsync_out,
  output logic                                vsync_out,
  output logic                                blank_out,
  output logic                                collision_pulse
);
  localparam int LANE_HEIGHT    = SCREEN_HEIGHT / NUM_LANES;
  localparam int OBSTACLE_WIDTH = LANE_HEIGHT - 2 * OBSTACLE_MARGIN;

  logic frame_latch;
  assign frame_latch = (hcount == 11'd0) && (vcount == 10'(SCREEN_HEIGHT));

  // Sprite snapshot; player is only drawn once a latch has captured it
  obstacle_t [NUM_OBSTACLES-1:0] snap;
  logic [LANE_W-1:0]             snap_plane;
  logic [10:0]                   snap_px;
  logic                          snap_pact;

  always_ff @(posedge system_clock_in) begin
    if (system_reset_in) begin
      snap       <= '0;
      snap_plane <= '0;
      snap_px    <= '0;
      snap_pact  <= 1'b0;
    end else if (frame_latch) begin
      snap       <= obstacles;
      snap_plane <= LANE_W'(player_lane);
      snap_px    <= player_x;
      snap_pact  <= 1'b1;
    end
  end

  // Stage 1: lane index and margin flag
  logic [9:0]        lane_div, lane_base, lane_off;
  logic [LANE_W-1:0] lane_c;
  logic              margin_c;

  assign lane_div  = vcount / 10'(LANE_HEIGHT);
  assign lane_c    = (lane_div > 10'(NUM_LANES - 1)) ? LANE_W'(NUM_LANES - 1)
                                                      : lane_div[LANE_W-1:0];
  assign lane_base = 10'(lane_c) * 10'(LANE_HEIGHT);
  assign lane_off  = vcount - lane_base;
  assign margin_c  = (lane_off < 10'(OBSTACLE_MARGIN)) ||
                     (lane_off >= 10'(LANE_HEIGHT - OBSTACLE_MARGIN));

  logic [1:0]        vld_pipe;
  logic [LANE_W-1:0] s1_lane, s2_lane;
  logic              s1_margin;
  logic [10:0]       s1_hcount;
  logic [2:0]        s1_sync, s2_sync;
  logic [NUM_OBSTACLES-1:0] hit_c, s2_hit;
  logic              phit_c, s2_phit;

  // Stage 2: per-sprite interval compare against the snapshot
  for (genvar g = 0; g < NUM_OBSTACLES; g++) begin : g_hit
    track_hit_unit #(.WIDTH(OBSTACLE_WIDTH), .SCREEN_WIDTH(SCREEN_WIDTH)) u_hit (
      .obs(snap[g]), .lane(s1_lane), .hcount(s1_hcount), .margin(s1_margin), .hit(hit_c[g])
    );
  end

  obstacle_t player_obs;
  assign player_obs = '{active: snap_pact, lane: snap_plane, position: snap_px};

  track_hit_unit #(.WIDTH(PLAYER_WIDTH), .SCREEN_WIDTH(SCREEN_WIDTH)) u_player_hit (
    .obs(player_obs), .lane(s1_lane), .hcount(s1_hcount), .margin(s1_margin), .hit(phit_c)
  );

  always_ff @(posedge system_clock_in) begin
    if (system_reset_in) begin
      vld_pipe  <= '0;
      s1_lane   <= '0;
      s1_margin <= 1'b0;
      s1_hcount <= '0;
      s1_sync   <= '0;
      s2_lane   <= '0;
      s2_hit    <= '0;
      s2_phit   <= 1'b0;
      s2_sync   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], 1'b1};
      s1_lane   <= lane_c;
      s1_margin <= margin_c;
      s1_hcount <= hcount;
      s1_sync   <= {hsync, vsync, blank};
      s2_lane   <= s1_lane;
      s2_hit    <= hit_c;
      s2_phit   <= phit_c;
      s2_sync   <= s1_sync;
    end
  end

  // Stage 3: lowest index wins, then colour select
  logic             any_hit, coll_now;
  logic [IDX_W-1:0] win_idx;
  logic [11:0]      color_c;

  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
      if (s2_hit[i]) begin
        any_hit = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    if (s2_sync[0] || !vld_pipe[1]) color_c = 12'h000;
    else if (s2_phit)               color_c = PLAYER_COLOR;
    else if (any_hit)               color_c = OBSTACLE_PALETTE[win_idx[2:0]];
    else                            color_c = lane_bg(s2_lane);
  end

  assign coll_now = vld_pipe[1] && s2_phit && any_hit && !s2_sync[0];

  logic collision_latch;

  always_ff @(posedge system_clock_in) begin
    if (system_reset_in) begin
      rgb             <= '0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      blank_out       <= 1'b0;
      collision_pulse <= 1'b0;
      collision_latch <= 1'b0;
    end else begin
      rgb                              <= color_c;
      {hsync_out, vsync_out, blank_out} <= s2_sync;
      // An overlap coinciding with the latch is credited to the frame ending now
      if (frame_latch) begin
        collision_pulse <= collision_latch | coll_now;
        collision_latch <= 1'b0;
      end else begin
        collision_pulse <= 1'b0;
        if (coll_now) collision_latch <= 1'b1;
      end
    end
  end
endmodule

// File: doc/track_render_pipe.md
Name: track_render_pipe

Overview:
- Parametrised, pipelined successor to the lane/obstacle pixel renderer in the video path.
- Draws N lanes, M obstacles and a player box into 12-bit RGB.
- Uses a per-frame snapshot of obstacle and player state so sprites cannot tear mid-frame.
- Delays hsync/vsync/blank to stay aligned with rgb, and reports a once-per-frame player/obstacle collision pulse to game logic.

Parameters:
SCREEN_WIDTH, 1024, visible pixels per line
SCREEN_HEIGHT, 768, visible lines
NUM_LANES, 3, lane count (2..8); LANE_HEIGHT = SCREEN_HEIGHT/NUM_LANES
NUM_OBSTACLES, 10, obstacle slots (1..16)
OBSTACLE_MARGIN, 16, vertical margin above/below sprites in each lane
PLAYER_WIDTH, 64, player box width in pixels
PLAYER_COLOR, 12'h0FF, player box colour

Ports:
system_clock_in  in  1  pixel/system clock
system_reset_in  in  1  synchronous, active-high reset
hcount  in  11  pixel column
vcount  in  10  pixel row
hsync  in  1  raw hsync
vsync  in  1  raw vsync
blank  in  1  raw blank
obstacles  in  obstacle[NUM_OBSTACLES]  live obstacle table (active, lane, position)
player_lane  in  clog2(NUM_LANES)  live player lane
player_x  in  11  live player left edge
rgb  out  12  pixel colour, aligned with *_out
hsync_out  out  1  hsync delayed 3
vsync_out  out  1  vsync delayed 3
blank_out  out  1  blank delayed 3
collision_pulse  out  1  one-cycle pulse at frame latch if previous frame had overlap

Behaviour:
- One clock (system_clock_in). Reset is synchronous and active-high (system_reset_in); all state clears on a clocked edge with reset high.
- Reset values: rgb=0, hsync_out=0, vsync_out=0, blank_out=0, collision_pulse=0. Pipeline valid flags, snapshot actives, player snapshot and collision latch all 0.
- Frame latch:
  - Fires on the cycle where hcount==0 && vcount==SCREEN_HEIGHT (first blank line).
  - Copies obstacles, player_lane and player_x into snapshot registers; rendering uses only the snapshot.
  - Same cycle: collision_pulse <= collision_latch; collision_latch <= 0.
  - If an overlap pixel and the latch coincide, the overlap belongs to the old frame. Cannot occur during blank; overlap is evaluated only when blank=0.
- Stage 1 (reg):
  - lane = vcount/LANE_HEIGHT, clamped to NUM_LANES-1.
  - in_margin = (vcount - lane*LANE_HEIGHT) < OBSTACLE_MARGIN || >= LANE_HEIGHT-OBSTACLE_MARGIN.
  - Forward hcount and sync/blank.
- Stage 2 (reg):
  - OBSTACLE_WIDTH = LANE_HEIGHT - 2*OBSTACLE_MARGIN.
  - hit[i] = snap[i].active && snap[i].lane==lane && position <= hcount < position+OBSTACLE_WIDTH. Compare in 12 bits, no wrap; right edge clips at screen.
  - player_hit uses the same half-open interval with PLAYER_WIDTH and player_lane.
  - Margin rows force all hits to 0.
- Stage 3 (reg):
  - Lowest-index hit wins.
  - Priority: player_hit -> PLAYER_COLOR; else any hit -> palette[index mod 8]; else lane background = 12'(lane)<<2.
  - blank_out=1 forces rgb=12'h000.
  - collision_latch <= 1 when player_hit && |hit && !blank.
- Latency: exactly 3 cycles from hcount/vcount/sync inputs to rgb/*_out, every cycle, with no stalls.
- Reset mid-frame: the snapshot clears, so no obstacles or player are drawn until the next frame latch. The sync pipeline refills in 3 cycles; no spurious collision_pulse.
- obstacle.lane >= NUM_LANES never matches a lane and is never drawn.

Decomposition:
- data.sv package holds:
  - obstacle typedef, extended with lane width sized for 8 lanes.
  - OBSTACLE_PALETTE[8] constant: F00, 0F0, FF0, F0F, 00F, F80, 8F0, FFF.
  - lane_bg function.
- One sub-module: track_hit_unit (stage-2 per-obstacle interval compare, generated NUM_OBSTACLES times).

Test Plan:
- Defaults; obstacle0 active lane1 pos 100; latch frame. At vcount=300: hcount=99 -> rgb 12'h004; hcount=100 -> 12'hF00; hcount=323 -> 12'hF00; hcount=324 -> 12'h004. Each rgb appears 3 cycles after its input.
- Obstacles 0 and 2 both lane0 pos 200; pixel (250,100) -> 12'hF00 (index 0 wins). Same pixel at vcount=10 (margin) -> 12'h000.
- Change obstacles mid-frame at vcount=400 -> rows 400..767 unchanged. New table visible only after the latch at vcount=768, hcount=0.
- player_lane=1, player_x=150 over obstacle0 at 100 -> player pixels 12'h0FF. collision_pulse=1 for exactly one cycle at the next latch, and 0 at the latch after if overlap is removed.
- hsync/vsync/blank toggling pattern -> *_out equals input delayed 3. blank=1 -> rgb 12'h000 regardless of hits.
- Assert reset at vcount=300 for 2 cycles -> all outputs 0 during reset and next cycle. No obstacles drawn until the next latch; collision_pulse stays 0.
